// File: rtl/fp_to_int_32_if.sv
// Start/done handshake bundle for the FP32-to-int32 converter.
// The requester drives start/a; the converter returns busy/done/result/flags.
interface fp_to_int_32_if;
  logic        start;
  logic [31:0] a;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        invalid;

  modport master (
    output start, a,
    input  busy, done, result, overflow, invalid
  );

  modport slave (
    input  start, a,
    output busy, done, result, overflow, invalid
  );
endinterface

// File: rtl/fp_to_int_32.sv
// FP32 to signed int32, one shift per cycle; latency n+1 (1 for specials), start ignored while busy.
// Truncates toward zero; FP2INT_ROUND_EN selects round-to-nearest-even on the magnitude.
module fp_to_int_32 (
  input  logic          clk,
  input  logic          reset,
  fp_to_int_32_if.slave cvt
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic        special_q, special_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic        inv_pend_q, inv_pend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        overflow_q, overflow_d;
  logic        invalid_q, invalid_d;
`ifdef FP2INT_ROUND_EN
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
`endif

  logic        a_sign;
  logic [7:0]  a_exp;
  logic [22:0] a_man;
  logic [7:0]  a_e;
  logic [4:0]  a_n;
  logic        round_inc;
  logic [31:0] mag;

  assign a_sign = cvt.a[31];
  assign a_exp  = cvt.a[30:23];
  assign a_man  = cvt.a[22:0];

  always_comb begin
    a_e = a_exp - 8'd127;
    a_n = (a_e >= 8'd23) ? 5'(a_e - 8'd23) : 5'(8'd23 - a_e);
  end

`ifdef FP2INT_ROUND_EN
  assign round_inc = guard_q & (sticky_q | acc_q[0]);
`else
  assign round_inc = 1'b0;
`endif
  assign mag = acc_q + {31'd0, round_inc};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    sign_d     = sign_q;
    special_d  = special_q;
    ovf_pend_d = ovf_pend_q;
    inv_pend_d = inv_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    invalid_d  = invalid_q;
`ifdef FP2INT_ROUND_EN
    guard_d    = guard_q;
    sticky_d   = sticky_q;
`endif

    case (state_q)
      IDLE: begin
        if (cvt.start) begin
          busy_d     = 1'b1;
          overflow_d = 1'b0;
          invalid_d  = 1'b0;
          sign_d     = a_sign;
          special_d  = 1'b0;
          ovf_pend_d = 1'b0;
          inv_pend_d = 1'b0;
          cnt_d      = 5'd0;
          left_d     = 1'b0;
`ifdef FP2INT_ROUND_EN
          guard_d    = 1'b0;
          sticky_d   = 1'b0;
`endif
          // Special results are stored pre-signed in acc and bypass negation.
          if (a_exp == 8'hFF && a_man != 23'd0) begin
            acc_d      = 32'h7FFF_FFFF;
            special_d  = 1'b1;
            inv_pend_d = 1'b1;
            state_d    = FINISH;
          end else if (cvt.a == 32'hCF00_0000) begin
            acc_d     = 32'h8000_0000;
            special_d = 1'b1;
            state_d   = FINISH;
          end else if (a_exp >= 8'd158) begin
            acc_d      = a_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            special_d  = 1'b1;
            ovf_pend_d = 1'b1;
            state_d    = FINISH;
          end else if (a_exp < 8'd127) begin
            acc_d   = 32'd0;
`ifdef FP2INT_ROUND_EN
            // 0.5 <= |a| < 1 looks like a guard bit with the fraction as sticky.
            guard_d  = (a_exp == 8'd126);
            sticky_d = (a_man != 23'd0);
`endif
            state_d = FINISH;
          end else begin
            acc_d   = {8'h00, 1'b1, a_man};
            left_d  = (a_e >= 8'd23);
            cnt_d   = a_n;
            state_d = (a_n == 5'd0) ? FINISH : SHIFT;
          end
        end
      end

      SHIFT: begin
        if (left_q) begin
          acc_d = {acc_q[30:0], 1'b0};
        end else begin
          acc_d = {1'b0, acc_q[31:1]};
`ifdef FP2INT_ROUND_EN
          guard_d  = acc_q[0];
          sticky_d = sticky_q | guard_q;
`endif
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        result_d   = special_q ? acc_q : (sign_q ? (32'd0 - mag) : mag);
        overflow_d = ovf_pend_q;
        invalid_d  = inv_pend_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= 32'd0;
      cnt_q      <= 5'd0;
      left_q     <= 1'b0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      inv_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 32'd0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
`ifdef FP2INT_ROUND_EN
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      sign_q     <= sign_d;
      special_q  <= special_d;
      ovf_pend_q <= ovf_pend_d;
      inv_pend_q <= inv_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
`ifdef FP2INT_ROUND_EN
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
`endif
    end
  end

  assign cvt.busy     = busy_q;
  assign cvt.done     = done_q;
  assign cvt.result   = result_q;
  assign cvt.overflow = overflow_q;
  assign cvt.invalid  = invalid_q;

endmodule

// File: tb/tb_fp_to_int_32.sv
// Directed-vector bench for fp_to_int_32 with hand-computed results and latencies.
module tb_fp_to_int_32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_to_int_32_if cvt_if ();

  fp_to_int_32 dut (
    .clk   (clk),
    .reset (reset),
    .cvt   (cvt_if)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int busy_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advances edge by edge until done is seen (bounded); busy must stay high meanwhile.
  task automatic wait_done(output int k);
    k = 0;
    busy_err = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (!cvt_if.done && !cvt_if.busy) busy_err++;
    end while (!cvt_if.done && k < 60);
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] exp_res,
                     input logic exp_ovf, input logic exp_inv, input int exp_lat);
    int k;
    cvt_if.start = 1'b1;
    cvt_if.a     = av;
    @(posedge clk);
    #1;
    cvt_if.start = 1'b0;
    cvt_if.a     = ~av;
    wait_done(k);
    chk({tag, ".lat"}, k, exp_lat);
    chk({tag, ".res"}, cvt_if.result, exp_res);
    chk({tag, ".flags"}, {30'd0, cvt_if.overflow, cvt_if.invalid}, {30'd0, exp_ovf, exp_inv});
    chk({tag, ".busy_wait"}, busy_err, 0);
    chk({tag, ".busy_done"}, {31'd0, cvt_if.busy}, 32'd0);
  endtask

  initial begin
    int k;
    int done_cnt;
    logic [31:0] exp_neg25;
    logic [31:0] exp_35;
    logic [31:0] exp_075;
`ifdef FP2INT_ROUND_EN
    exp_neg25 = 32'hFFFF_FFFE;
    exp_35    = 32'd4;
    exp_075   = 32'd1;
`else
    exp_neg25 = 32'hFFFF_FFFE;
    exp_35    = 32'd3;
    exp_075   = 32'd0;
`endif

    reset        = 1'b0;
    cvt_if.start = 1'b0;
    cvt_if.a     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ctl", {28'd0, cvt_if.busy, cvt_if.done, cvt_if.overflow, cvt_if.invalid}, 32'd0);
    chk("rst.res", cvt_if.result, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run("one",     32'h3F80_0000, 32'd1,          1'b0, 1'b0, 24);
    run("p2_30",   32'h4E80_0000, 32'h4000_0000,  1'b0, 1'b0, 8);
    run("m2_5",    32'hC020_0000, exp_neg25,      1'b0, 1'b0, 23);
    run("p3_5",    32'h4060_0000, exp_35,         1'b0, 1'b0, 23);
    run("p2_23",   32'h4B00_0000, 32'h0080_0000,  1'b0, 1'b0, 1);
    run("m100",    32'hC2C8_0000, 32'hFFFF_FF9C,  1'b0, 1'b0, 18);
    run("maxfin",  32'h4EFF_FFFF, 32'h7FFF_FF80,  1'b0, 1'b0, 8);
    run("p2_31",   32'h4F00_0000, 32'h7FFF_FFFF,  1'b1, 1'b0, 1);
    run("m2_31",   32'hCF00_0000, 32'h8000_0000,  1'b0, 1'b0, 1);
    run("m_big",   32'hCF00_0001, 32'h8000_0000,  1'b1, 1'b0, 1);
    run("minf",    32'hFF80_0000, 32'h8000_0000,  1'b1, 1'b0, 1);
    run("nan",     32'h7FC0_0000, 32'h7FFF_FFFF,  1'b0, 1'b1, 1);
    run("half",    32'h3F00_0000, 32'd0,          1'b0, 1'b0, 1);
    run("p0_75",   32'h3F40_0000, exp_075,        1'b0, 1'b0, 1);
    run("denorm",  32'h0000_0001, 32'd0,          1'b0, 1'b0, 1);

    // A second start while busy must be dropped.
    cvt_if.start = 1'b1;
    cvt_if.a     = 32'h3F80_0000;
    @(posedge clk);
    #1;
    cvt_if.start = 1'b0;
    cvt_if.a     = 32'd0;
    repeat (4) @(posedge clk);
    #1;
    cvt_if.start = 1'b1;
    cvt_if.a     = 32'h4E80_0000;
    @(posedge clk);
    #1;
    cvt_if.start = 1'b0;
    wait_done(k);
    chk("ign.lat", 5 + k, 24);
    chk("ign.res", cvt_if.result, 32'd1);

    // Start held high: the next conversion is accepted on the edge after done.
    cvt_if.start = 1'b1;
    cvt_if.a     = 32'h3F80_0000;
    @(posedge clk);
    #1;
    wait_done(k);
    chk("hold1.lat", k, 24);
    chk("hold1.res", cvt_if.result, 32'd1);
    cvt_if.a = 32'h4E80_0000;
    wait_done(k);
    cvt_if.start = 1'b0;
    chk("hold2.lat", k, 9);
    chk("hold2.res", cvt_if.result, 32'h4000_0000);

    // Reset in the middle of a shift sequence.
    cvt_if.start = 1'b1;
    cvt_if.a     = 32'h3F80_0000;
    @(posedge clk);
    #1;
    cvt_if.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst.ctl", {28'd0, cvt_if.busy, cvt_if.done, cvt_if.overflow, cvt_if.invalid}, 32'd0);
    chk("mrst.res", cvt_if.result, 32'd0);
    reset    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (cvt_if.done) done_cnt++;
    end
    chk("mrst.nodone", done_cnt, 0);
    run("after", 32'h42C8_0000, 32'd100, 1'b0, 1'b0, 18);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
